// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Multiplexed driver for an eight-digit, two-bank seven-segment display.
//   A prescaler divides clk by SCAN_DIV to produce a scan tick; a 2-bit scan
//   index selects digit k in the left bank (positions 0-3) and digit k+4 in
//   the right bank (positions 4-7) at the same time. New display data is
//   written into a shadow register and copied to the active register only
//   at a frame boundary, so a frame is never shown half old and half new.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   wr_en        one-cycle strobe: load wr_data into the shadow register
//   wr_data      eight hex nibbles, position p = wr_data[31-4p -: 4]
//   blank_lz     leading-zero blanking enable
//   dp_mask      decimal point per position (bit p -> position p)
//   tub_sel      active-high digit enables (bits k and k+4)
//   seg_led1234  segments {a,b,c,d,e,f,g,dp} for position k
//   seg_led5678  segments {a,b,c,d,e,f,g,dp} for position k+4
//   pending      shadow holds data not yet committed
//   frame_done   one-cycle pulse on every frame-boundary commit

module seg_scan_driver #(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic        blank_lz,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  tub_sel,
    output logic [7:0]  seg_led1234,
    output logic [7:0]  seg_led5678,
    output logic        pending,
    output logic        frame_done
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] presc;
    logic [1:0]    idx;
    logic [31:0]   shadow;
    logic [31:0]   active;

    logic          tick;
    logic          commit;
    logic [3:0]    nib [8];
    logic [7:0]    lead_zero;
    logic [7:0]    blank;
    logic [2:0]    lo_pos;
    logic [2:0]    hi_pos;
    logic [7:0]    tub_next;
    logic [7:0]    seg_lo_next;
    logic [7:0]    seg_hi_next;

    // Segment pattern {a..g} for one hex digit.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h7E;
            4'h1: s = 7'h30;
            4'h2: s = 7'h6D;
            4'h3: s = 7'h79;
            4'h4: s = 7'h33;
            4'h5: s = 7'h5B;
            4'h6: s = 7'h5F;
            4'h7: s = 7'h70;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h7B;
            4'hA: s = 7'h77;
            4'hB: s = 7'h1F;
            4'hC: s = 7'h4E;
            4'hD: s = 7'h3D;
            4'hE: s = 7'h4F;
            default: s = 7'h47;
        endcase
        return s;
    endfunction

    assign tick   = (presc == CW'(SCAN_DIV - 1));
    // The tick that wraps the index from 3 back to 0 is the frame boundary.
    assign commit = tick && (idx == 2'd3);

    assign lo_pos = {1'b0, idx};
    assign hi_pos = {1'b1, idx};

    always_comb begin
        for (int p = 0; p < 8; p++) begin
            nib[p] = active[31 - 4*p -: 4];
        end
        // lead_zero[p]: positions 0..p of the active value are all zero.
        lead_zero[0] = (nib[0] == 4'h0);
        for (int p = 1; p < 8; p++) begin
            lead_zero[p] = lead_zero[p-1] && (nib[p] == 4'h0);
        end
        // The rightmost digit always shows, so an all-zero value reads "0".
        blank = {1'b0, lead_zero[6:0]} & {8{blank_lz}};

        tub_next    = {4'b0001 << idx, 4'b0001 << idx};
        seg_lo_next = {blank[lo_pos] ? 7'h00 : hex7(nib[lo_pos]), dp_mask[lo_pos]};
        seg_hi_next = {blank[hi_pos] ? 7'h00 : hex7(nib[hi_pos]), dp_mask[hi_pos]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc       <= '0;
            idx         <= 2'd0;
            shadow      <= 32'h0;
            active      <= 32'h0;
            pending     <= 1'b0;
            frame_done  <= 1'b0;
            tub_sel     <= 8'h00;
            seg_led1234 <= 8'h00;
            seg_led5678 <= 8'h00;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                idx <= idx + 2'd1;
            end

            // Commit takes the pre-edge shadow; a coincident write refills it
            // and keeps pending set.
            if (commit) begin
                active <= shadow;
            end
            if (wr_en) begin
                shadow  <= wr_data;
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
            frame_done <= commit;

            // Outputs are refreshed every cycle so dp_mask and blank_lz
            // changes appear without waiting for a scan step.
            tub_sel     <= tub_next;
            seg_led1234 <= seg_lo_next;
            seg_led5678 <= seg_hi_next;
        end
    end

endmodule
